// File: rtl/rotary_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared types and helpers for the rotary encoder front-end.
//   quad_state_e : 2-bit quadrature state {A, B}. The encoding is Gray order,
//                  so every legal step changes exactly one bit.
//   step_e       : classification of a prev -> cur state pair.
//   DIR_CW/CCW   : encoding of the direction output.
//   quad_step()  : decodes a prev/cur pair into none / CW / CCW / illegal.
// -----------------------------------------------------------------------------
package rotary_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_CW   = 2'b01,
    STEP_CCW  = 2'b10,
    STEP_ERR  = 2'b11
  } step_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // CW order is 00 -> 01 -> 11 -> 10 -> 00. CCW is the reverse order.
  // A pair that flips both bits cannot be resolved to a direction, so it is
  // reported as an error.
  function automatic step_e quad_step(input quad_state_e prev, input quad_state_e cur);
    step_e res;
    res = STEP_NONE;
    case ({prev, cur})
      {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: res = STEP_CW;
      {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: res = STEP_CCW;
      {S00, S11}, {S11, S00}, {S01, S10}, {S10, S01}: res = STEP_ERR;
      default:                                        res = STEP_NONE;
    endcase
    return res;
  endfunction

endpackage : rotary_pkg

// File: rtl/rotary_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
// Brings one asynchronous pin into the clock domain and filters it.
// The pin first passes through a 2-flop synchroniser. The filtered output
// follows the synchronised value only after DEBOUNCE_CYCLES consecutive
// samples that differ from the current filtered value.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : raw asynchronous pin
//   filt_o  : synchronised and debounced level (registered)
// -----------------------------------------------------------------------------
module rotary_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability counter: any sample that agrees with the filtered value restarts
  // the count, so a glitch shorter than DEBOUNCE_CYCLES never reaches the output.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      filt_d = sync2_q;
      cnt_d  = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter and filtered-level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule : rotary_debounce

// File: rtl/rotary_quad_decoder_chk.sv
// -----------------------------------------------------------------------------
// rotary_quad_decoder_chk
// Checks output invariants of the decoder. It has no functional outputs.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   step_pulse_i  : decoder step pulse
//   sw_press_i    : switch press pulse
//   sw_level_i    : debounced switch level
//   irq_i         : interrupt pulse
// -----------------------------------------------------------------------------
module rotary_quad_decoder_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic step_pulse_i,
  input logic sw_press_i,
  input logic sw_level_i,
  input logic irq_i
);

  a_irq_is_or : assert property (@(posedge clk_i) disable iff (!rst_ni)
    irq_i == (step_pulse_i | sw_press_i));

  a_press_with_level : assert property (@(posedge clk_i) disable iff (!rst_ni)
    sw_press_i |-> sw_level_i);

  a_press_one_cycle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    sw_press_i |=> !sw_press_i);

endmodule : rotary_quad_decoder_chk

// File: rtl/rotary_quad_decoder.sv
// -----------------------------------------------------------------------------
// rotary_quad_decoder
// Turns raw rotary-encoder pins into a signed position count and event flags.
// All outputs are registered.
// Ports:
//   ACLK, ARESETN : clock and asynchronous active-low reset
//   enc_a, enc_b  : raw quadrature channels (asynchronous)
//   enc_sw        : raw push switch, active-high (asynchronous)
//   pos_clr       : one-cycle pulse that clears position and err_cnt
//   position      : signed position; wraps as two's complement
//   dir           : direction of the last valid step (1 = CW)
//   step_pulse    : one-cycle pulse on each valid step
//   sw_level      : debounced switch level
//   sw_press      : one-cycle pulse on a debounced switch press
//   err_cnt       : saturating count of double-bit transitions
//   irq           : step_pulse | sw_press
// -----------------------------------------------------------------------------
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int unsigned POS_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ERR_W           = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_sw,
  input  logic                    pos_clr,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    sw_level,
  output logic                    sw_press,
  output logic        [ERR_W-1:0] err_cnt,
  output logic                    irq
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic             a_f_s;
  logic             b_f_s;
  logic             sw_f_s;
  quad_state_e      cur_state_s;
  step_e            step_s;
  logic [POS_W-1:0] pos_step_s;
  logic [ERR_W-1:0] err_step_s;

  quad_state_e      prev_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             dir_q;
  logic             dir_d;
  logic             step_pulse_q;
  logic             step_pulse_d;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             sw_level_q;
  logic             sw_level_d;
  logic             sw_press_q;
  logic             sw_press_d;
  logic             irq_q;
  logic             irq_d;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .raw_i  (enc_a),
    .filt_o (a_f_s)
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .raw_i  (enc_b),
    .filt_o (b_f_s)
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .raw_i  (enc_sw),
    .filt_o (sw_f_s)
  );

  assign cur_state_s = quad_state_e'({a_f_s, b_f_s});
  assign step_s      = quad_step(prev_q, cur_state_s);

  // Next-state logic for the step decoder and the switch edge detector.
  always_comb begin
    pos_step_s   = pos_q;
    err_step_s   = err_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    case (step_s)
      STEP_CW: begin
        pos_step_s   = pos_q + POS_W'(1);
        dir_d        = DIR_CW;
        step_pulse_d = 1'b1;
      end
      STEP_CCW: begin
        pos_step_s   = pos_q - POS_W'(1);
        dir_d        = DIR_CCW;
        step_pulse_d = 1'b1;
      end
      STEP_ERR: begin
        if (err_q != ERR_MAX) begin
          err_step_s = err_q + ERR_W'(1);
        end else begin
          err_step_s = err_q;
        end
      end
      default: begin
        pos_step_s = pos_q;
      end
    endcase

    // A clear wins over a step or error in the same cycle. The step pulse
    // and direction for that step are still reported.
    if (pos_clr) begin
      pos_d = {POS_W{1'b0}};
      err_d = {ERR_W{1'b0}};
    end else begin
      pos_d = pos_step_s;
      err_d = err_step_s;
    end

    sw_level_d = sw_f_s;
    sw_press_d = sw_f_s & ~sw_level_q;
    irq_d      = step_pulse_d | sw_press_d;
  end

  // Decoder state and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prev_q       <= S00;
      pos_q        <= {POS_W{1'b0}};
      dir_q        <= 1'b0;
      step_pulse_q <= 1'b0;
      err_q        <= {ERR_W{1'b0}};
      sw_level_q   <= 1'b0;
      sw_press_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      prev_q       <= cur_state_s;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
      err_q        <= err_d;
      sw_level_q   <= sw_level_d;
      sw_press_q   <= sw_press_d;
      irq_q        <= irq_d;
    end
  end

  assign position   = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_pulse_q;
  assign err_cnt    = err_q;
  assign sw_level   = sw_level_q;
  assign sw_press   = sw_press_q;
  assign irq        = irq_q;

  rotary_quad_decoder_chk u_chk (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .step_pulse_i (step_pulse_q),
    .sw_press_i   (sw_press_q),
    .sw_level_i   (sw_level_q),
    .irq_i        (irq_q)
  );

endmodule : rotary_quad_decoder

// File: tb/tb_rotary_quad_decoder.sv
module tb_rotary_quad_decoder;

  localparam int POS_W = 4;
  localparam int DEB   = 4;
  localparam int ERR_W = 8;
  localparam int LAT   = 2 + DEB + 1;

  logic                    ACLK    = 1'b0;
  logic                    ARESETN = 1'b1;
  logic                    enc_a   = 1'b0;
  logic                    enc_b   = 1'b0;
  logic                    enc_sw  = 1'b0;
  logic                    pos_clr = 1'b0;
  logic signed [POS_W-1:0] position;
  logic                    dir;
  logic                    step_pulse;
  logic                    sw_level;
  logic                    sw_press;
  logic        [ERR_W-1:0] err_cnt;
  logic                    irq;

  int total = 0;
  int bad   = 0;

  int   cyc = 0;
  int   n_step = 0, n_irq = 0, n_press = 0;
  int   last_step_cyc = 0, last_press_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0;
  logic sw_prev = 1'b0;

  rotary_quad_decoder #(
    .POS_W(POS_W), .DEBOUNCE_CYCLES(DEB), .ERR_W(ERR_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .pos_clr(pos_clr), .position(position), .dir(dir), .step_pulse(step_pulse),
    .sw_level(sw_level), .sw_press(sw_press), .err_cnt(err_cnt), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  always @(negedge ACLK) begin
    if (step_pulse === 1'b1) begin
      n_step        <= n_step + 1;
      last_step_cyc <= cyc;
    end
    if (irq === 1'b1) n_irq <= n_irq + 1;
    if (sw_press === 1'b1) begin
      n_press        <= n_press + 1;
      last_press_cyc <= cyc;
    end
    if (sw_level === 1'b1 && sw_prev === 1'b0) last_rise_cyc <= cyc;
    if (sw_level === 1'b0 && sw_prev === 1'b1) last_fall_cyc <= cyc;
    sw_prev <= sw_level;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    int s0, p0;
    ARESETN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enc_a  = i[0];
      enc_b  = i[1];
      enc_sw = ~i[0];
      @(negedge ACLK);
      total++;
      if ({position, dir, step_pulse, sw_level, sw_press, err_cnt, irq} !== '0) begin
        bad++;
        $display("FAIL reset_hold: outputs=%h expected 0",
                 {position, dir, step_pulse, sw_level, sw_press, err_cnt, irq});
      end
    end
    enc_a = 1'b0; enc_b = 1'b0; enc_sw = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    s0 = n_step; p0 = n_press;
    @(posedge ACLK); #1;
    tick(12);
    total++;
    if (position !== 4'h0) begin bad++; $display("FAIL reset_pos: got %h expected 0", position); end
    total++;
    if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err: got %h expected 0", err_cnt); end
    total++;
    if (n_step != s0 || n_press != p0) begin
      bad++; $display("FAIL reset_pulses: steps=%0d presses=%0d expected none", n_step - s0, n_press - p0);
    end
  endtask

  task automatic test_cw();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [3:0] exp_pos;
    int s0, i0, t0;
    for (int i = 0; i < 4; i++) begin
      s0 = n_step; i0 = n_irq;
      enc_a = seq[i][1]; enc_b = seq[i][0]; t0 = cyc;
      tick(10);
      exp_pos = 4'(i + 1);
      total++;
      if (position !== exp_pos) begin bad++; $display("FAIL cw_pos[%0d]: got %h expected %h", i, position, exp_pos); end
      total++;
      if (dir !== 1'b1) begin bad++; $display("FAIL cw_dir[%0d]: got %b expected 1", i, dir); end
      total++;
      if (n_step != s0 + 1 || n_irq != i0 + 1) begin
        bad++; $display("FAIL cw_pulses[%0d]: steps=%0d irqs=%0d expected 1 each", i, n_step - s0, n_irq - i0);
      end
      total++;
      if (last_step_cyc - t0 != LAT) begin
        bad++; $display("FAIL cw_latency[%0d]: got %0d expected %0d", i, last_step_cyc - t0, LAT);
      end
    end
  endtask

  task automatic test_ccw_glitch();
    logic [1:0] seq [2] = '{2'b10, 2'b11};
    logic [3:0] exp_pos [2] = '{4'hF, 4'hE};
    int s0;
    pos_clr = 1'b1; tick(1); pos_clr = 1'b0; tick(1);
    total++;
    if (position !== 4'h0) begin bad++; $display("FAIL clr_pos: got %h expected 0", position); end
    for (int i = 0; i < 2; i++) begin
      s0 = n_step;
      enc_a = seq[i][1]; enc_b = seq[i][0];
      tick(10);
      total++;
      if (position !== exp_pos[i] || dir !== 1'b0 || n_step != s0 + 1) begin
        bad++; $display("FAIL ccw_step[%0d]: pos=%h dir=%b steps=%0d expected pos=%h dir=0 steps=1",
                        i, position, dir, n_step - s0, exp_pos[i]);
      end
    end
    s0 = n_step;
    enc_a = 1'b0; tick(2); enc_a = 1'b1;
    tick(15);
    total++;
    if (position !== 4'hE || n_step != s0 || dir !== 1'b0) begin
      bad++; $display("FAIL glitch: pos=%h steps=%0d dir=%b expected pos=e steps=0 dir=0", position, n_step - s0, dir);
    end
  endtask

  task automatic test_illegal();
    int s0;
    logic [1:0] ab;
    enc_a = 1'b1; enc_b = 1'b0; tick(10);
    enc_a = 1'b0; enc_b = 1'b0; tick(10);
    total++;
    if (position !== 4'h0 || dir !== 1'b1) begin
      bad++; $display("FAIL illegal_setup: pos=%h dir=%b expected pos=0 dir=1", position, dir);
    end
    s0 = n_step;
    enc_a = 1'b1; enc_b = 1'b1; tick(10);
    total++;
    if (err_cnt !== 8'd1 || position !== 4'h0 || n_step != s0) begin
      bad++; $display("FAIL illegal_one: err=%0d pos=%h steps=%0d expected err=1 pos=0 steps=0",
                      err_cnt, position, n_step - s0);
    end
    ab = 2'b11;
    for (int i = 0; i < 300; i++) begin
      ab = ~ab;
      enc_a = ab[1]; enc_b = ab[0];
      tick(8);
    end
    total++;
    if (err_cnt !== 8'hFF) begin bad++; $display("FAIL illegal_sat: err=%0d expected 255", err_cnt); end
    total++;
    if (position !== 4'h0 || n_step != s0 || dir !== 1'b1) begin
      bad++; $display("FAIL illegal_hold: pos=%h steps=%0d dir=%b expected pos=0 steps=0 dir=1",
                      position, n_step - s0, dir);
    end
  endtask

  task automatic test_wrap_clear();
    logic [1:0] seq [8] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    pos_clr = 1'b1; tick(1); pos_clr = 1'b0; tick(1);
    total++;
    if (position !== 4'h0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL clr_both: pos=%h err=%0d expected 0 0", position, err_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      enc_a = seq[i][1]; enc_b = seq[i][0]; tick(10);
    end
    total++;
    if (position !== 4'h7) begin bad++; $display("FAIL wrap_max: got %h expected 7", position); end
    enc_a = seq[7][1]; enc_b = seq[7][0]; tick(10);
    total++;
    if (position !== 4'h8) begin bad++; $display("FAIL wrap_neg: got %h expected 8", position); end
    enc_a = 1'b0; enc_b = 1'b0; tick(10);
    total++;
    if (err_cnt !== 8'd1 || position !== 4'h8) begin
      bad++; $display("FAIL wrap_err: err=%0d pos=%h expected err=1 pos=8", err_cnt, position);
    end
    // Step 00->01 lands in the same cycle that pos_clr is sampled.
    enc_a = 1'b0; enc_b = 1'b1;
    tick(6);
    pos_clr = 1'b1;
    tick(1);
    pos_clr = 1'b0;
    @(negedge ACLK);
    total++;
    if (step_pulse !== 1'b1 || irq !== 1'b1 || dir !== 1'b1) begin
      bad++; $display("FAIL clr_step_pulse: step=%b irq=%b dir=%b expected 1 1 1", step_pulse, irq, dir);
    end
    total++;
    if (position !== 4'h0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL clr_priority: pos=%h err=%0d expected 0 0", position, err_cnt);
    end
    @(posedge ACLK); #1;
    tick(4);
  endtask

  task automatic test_switch();
    int p0, i0, s0, t0, t1;
    enc_sw = 1'b1; tick(2); enc_sw = 1'b0; tick(2);
    p0 = n_press; i0 = n_irq; s0 = n_step;
    enc_sw = 1'b1; t0 = cyc;
    tick(20);
    total++;
    if (sw_level !== 1'b1) begin bad++; $display("FAIL sw_level_hi: got %b expected 1", sw_level); end
    total++;
    if (last_rise_cyc - t0 != LAT) begin
      bad++; $display("FAIL sw_rise_lag: got %0d expected %0d", last_rise_cyc - t0, LAT);
    end
    total++;
    if (n_press != p0 + 1 || n_irq != i0 + 1 || last_press_cyc != last_rise_cyc) begin
      bad++; $display("FAIL sw_press: presses=%0d irqs=%0d press_cyc=%0d rise_cyc=%0d expected 1 1 equal",
                      n_press - p0, n_irq - i0, last_press_cyc, last_rise_cyc);
    end
    enc_sw = 1'b0; t1 = cyc;
    tick(20);
    total++;
    if (sw_level !== 1'b0 || last_fall_cyc - t1 != LAT) begin
      bad++; $display("FAIL sw_release: level=%b lag=%0d expected 0 %0d", sw_level, last_fall_cyc - t1, LAT);
    end
    total++;
    if (n_press != p0 + 1 || n_irq != i0 + 1 || n_step != s0) begin
      bad++; $display("FAIL sw_no_release_pulse: presses=%0d irqs=%0d expected 1 1", n_press - p0, n_irq - i0);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    ARESETN = 1'b0;
    @(negedge ACLK);
    total++;
    if (position !== 4'h0 || dir !== 1'b0 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL mid_reset: pos=%h dir=%b err=%0d expected 0 0 0", position, dir, err_cnt);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    s0 = n_step;
    @(posedge ACLK); #1;
    tick(12);
    total++;
    if (position !== 4'h1 || dir !== 1'b1 || n_step != s0 + 1) begin
      bad++; $display("FAIL mid_reset_step: pos=%h dir=%b steps=%0d expected 1 1 1", position, dir, n_step - s0);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw_glitch();
    test_illegal();
    test_wrap_clear();
    test_switch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rotary_quad_decoder
